operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Decode-to-execute operand stage: drives register-file read addresses, takes back rd1/rd2, and applies EX/MEM/WB forwarding.
//  Registers the result into the ID/EX pipeline register, with a valid/ready handshake on both sides.
//  Detects load-use hazards, inserts one bubble per hazard and counts stall cycles.
//  Sits between the instruction decoder (upstream) and the ALU/execute stage (downstream).
// PARAMETERS
//  WIDTH         16  data/register width
//  ADDRESSWIDTH  4   register address width; address 2**ADDRESSWIDTH-1 (15) is the startIO port, not storage
//  OPW           4   opaque decoded-op field width, passed through unchanged
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  flush        in   1       sync squash of the ID/EX entry and the current input
//  in_valid     in   1       decoder has an instruction
//  in_ready     out  1       stage accepts the instruction this cycle
//  in_op        in   OPW     decoded op
//  in_ra1       in   AW      source reg 1
//  in_ra2       in   AW      source reg 2
//  in_use1      in   1       src1 is actually read
//  in_use2      in   1       src2 is actually read
//  in_wa        in   AW      destination reg
//  in_writes    in   1       instruction writes a register
//  in_is_load   in   1       instruction is a load
//  ra1          out  AW      regfile read address 1 (= in_ra1, combinational)
//  ra2          out  AW      regfile read address 2 (= in_ra2, combinational)
//  rd1          in   WIDTH   regfile read data 1, same cycle
//  rd2          in   WIDTH   regfile read data 2, same cycle
//  ex_fwd_en    in   1       EX result valid (never asserted for loads)
//  ex_fwd_wa    in   AW      EX destination
//  ex_fwd_d     in   WIDTH   EX result
//  mem_fwd_en   in   1       MEM result valid (includes load data)
//  mem_fwd_wa   in   AW      MEM destination
//  mem_fwd_d    in   WIDTH   MEM result
//  wb_we        in   1       WB write enable (same net as regfile we3)
//  wb_wa        in   AW      WB destination (regfile wa3)
//  wb_wd        in   WIDTH   WB data (regfile wd3)
//  out_valid    out  1       ID/EX entry valid
//  out_ready    in   1       execute stage consumes the entry
//  out_op       out  OPW     registered op
//  out_a        out  WIDTH   registered operand 1
//  out_b        out  WIDTH   registered operand 2
//  out_wa       out  AW      registered destination
//  out_writes   out  1       registered write flag
//  out_is_load  out  1       registered load flag
//  stall_cnt    out  16      saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0; out_op/a/b/wa=0; out_writes=0; out_is_load=0; stall_cnt=0.
//  Forward select, per source:
//   - src==15: use rdN unchanged; no forwarding; writes to 15 are never forwarded.
//   - otherwise priority EX > MEM > WB > rdN; a level matches when its en=1 and its wa==src.
//   - WB bypass is mandatory: the regfile writes on the edge, so rdN is stale in that cycle.
//  Hazard, combinational:
//   hazard = in_valid & out_valid & out_is_load & out_writes & out_wa!=15 & ((in_use1 & in_ra1==out_wa) | (in_use2 & in_ra2==out_wa)).
//  Handshake:
//   - adv = !out_valid | out_ready.
//   - in_ready = adv & !hazard & !flush.
//   - Accept when in_valid & in_ready: next out_* = op fields + forwarded operands; out_valid=1. Latency 1 cycle.
//   - adv & !accept: out_valid<=0 (bubble); other out_* hold.
//   - !adv: all out_* hold, stable while out_valid & !out_ready.
//  Hazard cycle: input not accepted; if out_ready=1, a bubble is emitted; the load proceeds to MEM; next cycle the MEM forward supplies the data.
//  stall_cnt: +1 in every cycle with hazard=1 and flush=0; saturates at 16'hFFFF; never wraps.
//  flush has priority over everything: out_valid<=0 next edge; in_ready=0; stall_cnt unchanged.
//  Simultaneous EX and MEM to the same wa: EX wins (younger). Operand wrap/overflow: none; pure pass-through.
//  rst_n asserted mid-stall or mid-handshake: immediate clear; first accept possible in the first cycle after release.
// STRUCTURE
//  Shared package (pipeline types):
//   - localparam REG_IO = 4'hF
//   - typedef idex_t {op, a, b, wa, writes, is_load}
//   - typedef fwd_t {en, wa, d}
//  Sub-module fwd_mux: one per source, 2 instances; combinational priority select.
//  Top holds the hazard logic, the ID/EX register and the counter.
// TESTING
//  1. Reset release, in_valid=1, ra1=2, rd1=0x0011, no forwarding -> next cycle out_valid=1, out_a=0x0011.
//  2. ex_fwd(en,wa=3,d=0xAAAA) and mem_fwd(en,wa=3,d=0x5555), in_ra1=3 -> out_a=0xAAAA; EX removed -> 0x5555.
//  3. wb_we=1, wa=4, wd=0x1234, rd2=old 0x0000, in_ra2=4 -> out_b=0x1234.
//  4. Load to r5 in ID/EX, next instr uses r5 -> in_ready=0 one cycle, bubble, stall_cnt=1; then mem_fwd d=0x0BEE -> out_a=0x0BEE.
//  5. out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0; flush -> out_valid=0 next edge.
//  6. ra1=15, rd1=0x0001, ex_fwd wa=15 -> out_a=0x0001; async rst_n pulse mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared pipeline types for the decode-to-execute operand stage:
// the ID/EX register layout and a forwarding-source record.
package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;

  // Highest register address is the startIO port, never storage, never forwarded
  localparam logic [ADDR_W-1:0] REG_IO = 4'hF;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] wa;
    logic              writes;
    logic              is_load;
  } idex_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] d;
  } fwd_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decoder / regfile / bypass / execute signals of the operand stage.
// slave is the operand stage itself; master is everything around it.
interface operand_fetch_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4,
  parameter int OPW   = 4
);
  logic             flush;
  logic             in_valid, in_ready;
  logic [OPW-1:0]   in_op;
  logic [AW-1:0]    in_ra1, in_ra2, in_wa;
  logic             in_use1, in_use2, in_writes, in_is_load;
  logic [AW-1:0]    ra1, ra2;
  logic [WIDTH-1:0] rd1, rd2;
  logic             ex_fwd_en, mem_fwd_en, wb_we;
  logic [AW-1:0]    ex_fwd_wa, mem_fwd_wa, wb_wa;
  logic [WIDTH-1:0] ex_fwd_d, mem_fwd_d, wb_wd;
  logic             out_valid, out_ready;
  logic [OPW-1:0]   out_op;
  logic [WIDTH-1:0] out_a, out_b;
  logic [AW-1:0]    out_wa;
  logic             out_writes, out_is_load;
  logic [15:0]      stall_cnt;

  modport slave (
    input  flush, in_valid, in_op, in_ra1, in_ra2, in_wa, in_use1, in_use2,
           in_writes, in_is_load, rd1, rd2,
           ex_fwd_en, ex_fwd_wa, ex_fwd_d, mem_fwd_en, mem_fwd_wa, mem_fwd_d,
           wb_we, wb_wa, wb_wd, out_ready,
    output in_ready, ra1, ra2, out_valid, out_op, out_a, out_b, out_wa,
           out_writes, out_is_load, stall_cnt
  );

  modport master (
    output flush, in_valid, in_op, in_ra1, in_ra2, in_wa, in_use1, in_use2,
           in_writes, in_is_load, rd1, rd2,
           ex_fwd_en, ex_fwd_wa, ex_fwd_d, mem_fwd_en, mem_fwd_wa, mem_fwd_d,
           wb_we, wb_wa, wb_wd, out_ready,
    input  in_ready, ra1, ra2, out_valid, out_op, out_a, out_b, out_wa,
           out_writes, out_is_load, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// Per-source operand bypass: EX > MEM > WB > regfile, never for the IO port.
module operand_fetch_fwd_mux
  import operand_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] i_src,
  input  logic [DATA_W-1:0] i_rd,
  input  fwd_t              i_ex,
  input  fwd_t              i_mem,
  input  fwd_t              i_wb,
  output logic [DATA_W-1:0] o_d
);
  // WB level is required: the regfile write lands on the same edge, so rd is stale
  always_comb begin
    o_d = i_rd;
    if (i_src != REG_IO) begin
      if (i_ex.en && i_ex.wa == i_src)        o_d = i_ex.d;
      else if (i_mem.en && i_mem.wa == i_src) o_d = i_mem.d;
      else if (i_wb.en && i_wb.wa == i_src)   o_d = i_wb.d;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand stage: regfile read, bypass, load-use hazard bubble and the
// ID/EX pipeline register with valid/ready on both sides.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH        = DATA_W,
  parameter int ADDRESSWIDTH = ADDR_W,
  parameter int OPW          = OP_W
) (
  input logic           clk,
  input logic           rst_n,
  operand_fetch_if.slave bus
);
  fwd_t                          w_ex, w_mem, w_wb;
  logic [1:0][ADDR_W-1:0]        w_src;
  logic [1:0][DATA_W-1:0]        w_rd, w_opnd;
  logic                          w_hazard, w_adv, w_in_ready, w_accept;
  idex_t                         r_idex;
  logic                          r_vld;
  logic [CNT_W-1:0]              r_stall;

  assign w_ex  = '{en: bus.ex_fwd_en,  wa: bus.ex_fwd_wa,  d: bus.ex_fwd_d};
  assign w_mem = '{en: bus.mem_fwd_en, wa: bus.mem_fwd_wa, d: bus.mem_fwd_d};
  assign w_wb  = '{en: bus.wb_we,      wa: bus.wb_wa,      d: bus.wb_wd};
  assign w_src = {bus.in_ra2, bus.in_ra1};
  assign w_rd  = {bus.rd2, bus.rd1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    operand_fetch_fwd_mux u_fwd (
      .i_src (w_src[g]),
      .i_rd  (w_rd[g]),
      .i_ex  (w_ex),
      .i_mem (w_mem),
      .i_wb  (w_wb),
      .o_d   (w_opnd[g])
    );
  end

  // Load in ID/EX whose result a consumer needs: EX cannot bypass loads, wait one cycle for MEM
  assign w_hazard = bus.in_valid && r_vld && r_idex.is_load && r_idex.writes &&
                    (r_idex.wa != REG_IO) &&
                    ((bus.in_use1 && bus.in_ra1 == r_idex.wa) ||
                     (bus.in_use2 && bus.in_ra2 == r_idex.wa));
  assign w_adv      = !r_vld || bus.out_ready;
  assign w_in_ready = w_adv && !w_hazard && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_idex <= '0;
    end else if (bus.flush) begin
      r_vld  <= 1'b0;
    end else if (w_adv) begin
      r_vld  <= w_accept;
      if (w_accept)
        r_idex <= '{op: bus.in_op, a: w_opnd[0], b: w_opnd[1], wa: bus.in_wa,
                    writes: bus.in_writes, is_load: bus.in_is_load};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (w_hazard && !bus.flush && r_stall != '1)
      r_stall <= r_stall + 1'b1;
  end

  assign bus.ra1         = bus.in_ra1;
  assign bus.ra2         = bus.in_ra2;
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_vld;
  assign bus.out_op      = r_idex.op;
  assign bus.out_a       = r_idex.a;
  assign bus.out_b       = r_idex.b;
  assign bus.out_wa      = r_idex.wa;
  assign bus.out_writes  = r_idex.writes;
  assign bus.out_is_load = r_idex.is_load;
  assign bus.stall_cnt   = r_stall;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for forwarding/hazard
// cases plus hand sequences for backpressure, flush and async reset.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  operand_fetch_if #(.WIDTH(16), .AW(4), .OPW(4)) bus ();
  operand_fetch u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int vld, op, ra1, ra2, u1, u2, wa, wr, ld, rd1, rd2;
    int exe, exwa, exd, mme, mmwa, mmd, wbe, wbwa, wbd, ordy;
    int e_rdy, e_vld, e_a, e_b, e_wa, e_stall;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = v.vld[0];     bus.in_op = 4'(v.op);
    bus.in_ra1 = 4'(v.ra1);      bus.in_ra2 = 4'(v.ra2);
    bus.in_use1 = v.u1[0];       bus.in_use2 = v.u2[0];
    bus.in_wa = 4'(v.wa);        bus.in_writes = v.wr[0];
    bus.in_is_load = v.ld[0];
    bus.rd1 = 16'(v.rd1);        bus.rd2 = 16'(v.rd2);
    bus.ex_fwd_en = v.exe[0];    bus.ex_fwd_wa = 4'(v.exwa);  bus.ex_fwd_d = 16'(v.exd);
    bus.mem_fwd_en = v.mme[0];   bus.mem_fwd_wa = 4'(v.mmwa); bus.mem_fwd_d = 16'(v.mmd);
    bus.wb_we = v.wbe[0];        bus.wb_wa = 4'(v.wbwa);      bus.wb_wd = 16'(v.wbd);
    bus.out_ready = v.ordy[0];
  endtask

  // Simple instruction: reads ra1 (rd1 supplied), writes wa, no forwarding
  function automatic vec_t instr(input int ra1, input int rd1, input int wa,
                                 input int ld, input int ordy);
    vec_t v;
    v = '{default: 0};
    v.vld = 1; v.op = 4'hA; v.ra1 = ra1; v.u1 = 1; v.rd1 = rd1;
    v.wa = wa; v.wr = 1; v.ld = ld; v.ordy = ordy;
    return v;
  endfunction

  initial begin
    vec_t v;
    bus.flush = 1'b0;
    v = '{default: 0};
    drive(v);

    //        vld op ra1 ra2 u1 u2 wa wr ld rd1     rd2      exe exwa exd      mme mmwa mmd      wbe wbwa wbd      ordy rdy vld a        b        wa stall
    tbl[0]  = '{1, 1,  2,  0, 1, 0, 6, 1, 0, 'h0011, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  1,  'h0011, 'h0000, 6, 0};
    tbl[1]  = '{1, 2,  3,  7, 1, 1, 7, 1, 0, 'h0003, 'h0077, 1, 3,  'hAAAA,  1, 3,  'h5555,  0, 0,  0,       1,   1,  1,  'hAAAA, 'h0077, 7, 0};
    tbl[2]  = '{1, 2,  3,  7, 1, 1, 7, 1, 0, 'h0003, 'h0077, 0, 0,  0,       1, 3,  'h5555,  0, 0,  0,       1,   1,  1,  'h5555, 'h0077, 7, 0};
    tbl[3]  = '{1, 4,  1,  4, 1, 1, 8, 1, 0, 'h0101, 'h0000, 0, 0,  0,       0, 0,  0,       1, 4,  'h1234,  1,   1,  1,  'h0101, 'h1234, 8, 0};
    tbl[4]  = '{1, 5, 15, 15, 1, 1, 1, 1, 0, 'h0001, 'h0002, 1, 15, 'hFFFF,  1, 15, 'hEEEE,  1, 15, 'hDDDD,  1,   1,  1,  'h0001, 'h0002, 1, 0};
    tbl[5]  = '{1, 6,  8,  0, 1, 0, 5, 1, 1, 'h0080, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  1,  'h0080, 'h0000, 5, 0};
    tbl[6]  = '{1, 7,  5,  0, 1, 0, 9, 1, 0, 'h0000, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   0,  0,  'h0080, 'h0000, 5, 1};
    tbl[7]  = '{1, 7,  5,  0, 1, 0, 9, 1, 0, 'h0000, 'h0000, 0, 0,  0,       1, 5,  'h0BEE,  0, 0,  0,       1,   1,  1,  'h0BEE, 'h0000, 9, 1};
    tbl[8]  = '{1, 8,  2,  2, 1, 1, 2, 1, 0, 'h0002, 'h0002, 0, 0,  0,       1, 2,  'h2222,  1, 2,  'h3333,  1,   1,  1,  'h2222, 'h2222, 2, 1};
    tbl[9]  = '{1, 9,  0,  0, 0, 0, 10,1, 1, 'h0000, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  1,  'h0000, 'h0000, 10,1};
    tbl[10] = '{1, 10,10, 10, 0, 0, 11,1, 0, 'h1111, 'h2222, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  1,  'h1111, 'h2222, 11,1};
    tbl[11] = '{1, 11, 1,  0, 1, 0, 15,1, 1, 'h0001, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  1,  'h0001, 'h0000, 15,1};
    tbl[12] = '{1, 12,15,  0, 1, 0, 3, 1, 0, 'h00F0, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  1,  'h00F0, 'h0000, 3, 1};
    tbl[13] = '{0, 0,  0,  0, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 0,  0,       0, 0,  0,       0, 0,  0,       1,   1,  0,  'h00F0, 'h0000, 3, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_a", int'(bus.out_a), 0);
    chk("rst_out_b", int'(bus.out_b), 0);
    chk("rst_out_op", int'(bus.out_op), 0);
    chk("rst_out_wa", int'(bus.out_wa), 0);
    chk("rst_out_flags", int'({bus.out_writes, bus.out_is_load}), 0);
    chk("rst_stall", int'(bus.stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_in_ready", i), int'(bus.in_ready), tbl[i].e_rdy);
      chk($sformatf("v%0d_ra1", i), int'(bus.ra1), tbl[i].ra1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), int'(bus.out_valid), tbl[i].e_vld);
      chk($sformatf("v%0d_out_a", i), int'(bus.out_a), tbl[i].e_a);
      chk($sformatf("v%0d_out_b", i), int'(bus.out_b), tbl[i].e_b);
      chk($sformatf("v%0d_out_wa", i), int'(bus.out_wa), tbl[i].e_wa);
      chk($sformatf("v%0d_stall", i), int'(bus.stall_cnt), tbl[i].e_stall);
    end

    // Backpressure holds the entry, then flush drops it
    @(negedge clk);
    drive(instr(2, 'h0042, 3, 0, 1));
    @(posedge clk); #1;
    chk("bp_accept_valid", int'(bus.out_valid), 1);
    chk("bp_accept_a", int'(bus.out_a), 'h0042);
    chk("bp_accept_op", int'(bus.out_op), 'hA);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(instr(2, 'h9999, 4, 0, 0));
      #1;
      chk($sformatf("bp%0d_in_ready", c), int'(bus.in_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), int'(bus.out_valid), 1);
      chk($sformatf("bp%0d_a", c), int'(bus.out_a), 'h0042);
      chk($sformatf("bp%0d_wa", c), int'(bus.out_wa), 3);
    end
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("flush_valid", int'(bus.out_valid), 0);
    chk("flush_stall", int'(bus.stall_cnt), 1);
    @(negedge clk);
    bus.flush = 1'b0;

    // Hazard under backpressure counts; hazard under flush does not
    drive(instr(1, 'h0777, 5, 1, 1));
    @(posedge clk); #1;
    chk("ld_valid", int'(bus.out_valid), 1);
    chk("ld_is_load", int'(bus.out_is_load), 1);
    @(negedge clk);
    drive(instr(5, 'h0000, 9, 0, 0));
    #1;
    chk("hz_bp_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("hz_bp_valid", int'(bus.out_valid), 1);
    chk("hz_bp_a", int'(bus.out_a), 'h0777);
    chk("hz_bp_stall", int'(bus.stall_cnt), 2);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("hz_fl_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("hz_fl_valid", int'(bus.out_valid), 0);
    chk("hz_fl_stall", int'(bus.stall_cnt), 2);
    @(negedge clk);
    bus.flush = 1'b0;

    // Async reset in the middle of a stall
    drive(instr(1, 'h0555, 5, 1, 1));
    @(posedge clk); #1;
    chk("rs_ld_valid", int'(bus.out_valid), 1);
    @(negedge clk);
    drive(instr(5, 'h0000, 9, 0, 0));
    @(posedge clk); #1;
    chk("rs_pre_stall", int'(bus.stall_cnt), 3);
    chk("rs_pre_valid", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_valid", int'(bus.out_valid), 0);
    chk("rs_a", int'(bus.out_a), 0);
    chk("rs_wa", int'(bus.out_wa), 0);
    chk("rs_is_load", int'(bus.out_is_load), 0);
    chk("rs_stall", int'(bus.stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(instr(2, 'h0123, 4, 0, 1));
    #1;
    chk("rs_rel_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("rs_rel_valid", int'(bus.out_valid), 1);
    chk("rs_rel_a", int'(bus.out_a), 'h0123);
    chk("rs_rel_stall", int'(bus.stall_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
